// File: rtl/demux_deser8.sv
// 1-to-8 demultiplexing deserializer: steers one serial bit per handshake into a slot
// chosen by a 3-bit counter, then presents the assembled byte on a valid/ready port.

module demux_deser8_slot (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wr,
  input  logic din,
  output logic q,
  output logic nxt
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= 1'b0;
    else if (wr)    q <= din;
  end

  // Bit the word would hold if completed this cycle.
  assign nxt = wr ? din : q;
endmodule

module demux_deser8 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_word,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] bit_cnt
);
  localparam int NUM_LANES = 8;

  logic [2:0]           cnt;
  logic [2:0]           pos;
  logic [NUM_LANES-1:0] sel;
  logic [NUM_LANES-1:0] partial;
  logic [NUM_LANES-1:0] word_nxt;
  logic                 accept, load, drain, complete;

  // Only the completing bit can stall: it needs a free holding slot.
  assign in_ready = !((cnt == 3'd7) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && !flush;
  assign drain    = out_valid && out_ready;
  assign complete = load && (cnt == 3'd7);
  assign pos      = LSB_FIRST ? cnt : ~cnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    assign sel[i] = (pos == 3'(i));
    demux_deser8_slot u_slot (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .wr  (load && sel[i]),
      .din (serial_in),
      .q   (partial[i]),
      .nxt (word_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      out_word  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      if (flush)     cnt <= 3'd0;
      else if (load) cnt <= cnt + 3'd1;

      if (complete) begin
        out_word  <= word_nxt;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bit_cnt = cnt;
endmodule
